// File: rtl/cmd_dispatcher.sv
// Command dispatcher: decodes a command byte, runs one channel block,
// muxes its transmit requests to the UART, NAKs unknown commands.
// Ports: clk/reset; rx_ready/rx_data from the receiver; tx_active from the
//   transmitter; ch_done/ch_tx_data/ch_tx_start from the channels;
//   ch_activate to the channels; tx_data/tx_start to the transmitter;
//   state_code for the display; err_unknown/err_timeout pulses.
module cmd_dispatcher #(
  parameter int               N_CH           = 4,
  parameter logic [N_CH*8-1:0] CODES         = {8'h72, 8'h71, 8'h22, 8'h21},
  parameter logic [7:0]       NAK_BYTE       = 8'h3F,
  parameter int               TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_ready,
  input  logic [7:0]        rx_data,
  input  logic              tx_active,
  input  logic [N_CH-1:0]   ch_done,
  input  logic [N_CH*8-1:0] ch_tx_data,
  input  logic [N_CH-1:0]   ch_tx_start,
  output logic [N_CH-1:0]   ch_activate,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic [7:0]        state_code,
  output logic              err_unknown,
  output logic              err_timeout
);

  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] T_LAST =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_NAK, S_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_CH-1:0] act_q, act_d;
  logic [7:0]      txd_q, txd_d;
  logic            txs_q, txs_d;
  logic [7:0]      code_q, code_d;
  logic            unk_q, unk_d;
  logic            to_q, to_d;

  logic            hit;
  logic [SW-1:0]   hit_sel;

  // Parallel compare; scanning downward leaves the lowest match.
  always_comb begin
    hit     = 1'b0;
    hit_sel = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rx_data == CODES[8*i +: 8]) begin
        hit     = 1'b1;
        hit_sel = SW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    txd_d   = txd_q;
    txs_d   = 1'b0;
    unk_d   = 1'b0;
    to_d    = 1'b0;
    code_d  = code_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_ready) begin
          if (hit) begin
            sel_d          = hit_sel;
            act_d          = '0;
            act_d[hit_sel] = 1'b1;
            cnt_d          = '0;
            state_d        = S_RUN;
          end else begin
            unk_d   = 1'b1;
            state_d = S_NAK;
          end
        end
      end
      S_RUN: begin
        txd_d = ch_tx_data[8*sel_q +: 8];
        txs_d = ch_tx_start[sel_q];
        // Done takes priority over an expiry in the same cycle.
        if (ch_done[sel_q]) begin
          act_d   = '0;
          state_d = S_DRAIN;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (cnt_q == T_LAST) begin
            act_d   = '0;
            to_d    = 1'b1;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_NAK: begin
        if (!tx_active) begin
          txd_d   = NAK_BYTE;
          txs_d   = 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!rx_ready && !tx_active) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    unique case (state_d)
      S_IDLE:  code_d = 8'h00;
      S_RUN:   code_d = CODES[8*sel_d +: 8];
      S_NAK:   code_d = 8'hEE;
      S_DRAIN: code_d = 8'h01;
      default: code_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      act_q   <= '0;
      txd_q   <= '0;
      txs_q   <= 1'b0;
      code_q  <= '0;
      unk_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      txd_q   <= txd_d;
      txs_q   <= txs_d;
      code_q  <= code_d;
      unk_q   <= unk_d;
      to_q    <= to_d;
    end
  end

  assign ch_activate = act_q;
  assign tx_data     = txd_q;
  assign tx_start    = txs_q;
  assign state_code  = code_q;
  assign err_unknown = unk_q;
  assign err_timeout = to_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Bench for cmd_dispatcher: vector table with scoreboard queue on the
// default build, plus watchdog and duplicate-code builds.
module tb_cmd_dispatcher;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_active = 1'b0;
  logic [3:0]  ch_done = 4'h0;
  logic [31:0] ch_tx_data = 32'h0;
  logic [3:0]  ch_tx_start = 4'h0;

  logic [3:0] act0, act1, act2;
  logic [7:0] txd0, txd1, txd2;
  logic       txs0, txs1, txs2;
  logic [7:0] code0, code1, code2;
  logic       unk0, unk1, unk2;
  logic       to0, to1, to2;

  always #5 clk = ~clk;

  cmd_dispatcher u0 (
    .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_active(tx_active), .ch_done(ch_done), .ch_tx_data(ch_tx_data),
    .ch_tx_start(ch_tx_start), .ch_activate(act0), .tx_data(txd0),
    .tx_start(txs0), .state_code(code0), .err_unknown(unk0),
    .err_timeout(to0)
  );

  cmd_dispatcher #(.TIMEOUT_CYCLES(100)) u1 (
    .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_active(tx_active), .ch_done(ch_done), .ch_tx_data(ch_tx_data),
    .ch_tx_start(ch_tx_start), .ch_activate(act1), .tx_data(txd1),
    .tx_start(txs1), .state_code(code1), .err_unknown(unk1),
    .err_timeout(to1)
  );

  cmd_dispatcher #(.CODES({8'h30, 8'h30, 8'h10, 8'h10})) u2 (
    .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_active(tx_active), .ch_done(ch_done), .ch_tx_data(ch_tx_data),
    .ch_tx_start(ch_tx_start), .ch_activate(act2), .tx_data(txd2),
    .tx_start(txs2), .state_code(code2), .err_unknown(unk2),
    .err_timeout(to2)
  );

  typedef struct {
    logic        rr;
    logic [7:0]  rd;
    logic        ta;
    logic [3:0]  dn;
    logic [3:0]  ts;
    logic [31:0] td;
    logic [3:0]  e_act;
    logic        e_ts;
    logic [7:0]  e_td;
    logic [7:0]  e_code;
    logic        e_unk;
    logic        e_to;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rr, input logic [7:0] rd, input logic ta,
    input logic [3:0] dn, input logic [3:0] ts, input logic [31:0] td,
    input logic [3:0] ea, input logic ets, input logic [7:0] etd,
    input logic [7:0] ec, input logic eu, input logic eto);
    vec_t v;
    v.rr = rr; v.rd = rd; v.ta = ta; v.dn = dn; v.ts = ts; v.td = td;
    v.e_act = ea; v.e_ts = ets; v.e_td = etd; v.e_code = ec;
    v.e_unk = eu; v.e_to = eto;
    return v;
  endfunction

  // Drive at the falling edge, compare 1 time unit after the next rise.
  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    rx_ready = v.rr; rx_data = v.rd; tx_active = v.ta;
    ch_done = v.dn; ch_tx_start = v.ts; ch_tx_data = v.td;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk($sformatf("v%0d act", idx), 32'(act0), 32'(e.e_act));
    chk($sformatf("v%0d tx_start", idx), 32'(txs0), 32'(e.e_ts));
    chk($sformatf("v%0d tx_data", idx), 32'(txd0), 32'(e.e_td));
    chk($sformatf("v%0d code", idx), 32'(code0), 32'(e.e_code));
    chk($sformatf("v%0d err_unk", idx), 32'(unk0), 32'(e.e_unk));
    chk($sformatf("v%0d err_to", idx), 32'(to0), 32'(e.e_to));
    @(negedge clk);
  endtask

  task automatic clear_in();
    rx_ready = 0; rx_data = 0; tx_active = 0;
    ch_done = 0; ch_tx_start = 0; ch_tx_data = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Dispatch ch0 on the watchdog build and watch it for 200 cycles.
  task automatic wd_run(input bit give_done, output int hi,
                        output int tos);
    hi = 0;
    tos = 0;
    rx_ready = 1'b1;
    rx_data = 8'h21;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (act1 != 4'b0) hi++;
      if (to1) tos++;
      rx_ready = 1'b0;
      ch_done = (give_done && i == 100) ? 4'b0001 : 4'b0000;
    end
    ch_done = 4'b0;
  endtask

  initial begin
    int hi;
    int tos;
    clear_in();
    #1 reset = 1'b1;
    #1;
    chk("rst act", 32'(act0), 32'h0);
    chk("rst tx_start", 32'(txs0), 32'h0);
    chk("rst tx_data", 32'(txd0), 32'h0);
    chk("rst code", 32'(code0), 32'h0);
    chk("rst err_unk", 32'(unk0), 32'h0);
    chk("rst err_to", 32'(to0), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    vecs.push_back(mk(0, 8'h00, 0, 4'h0, 4'h0, 32'h0,
                      4'h0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'h22, 0, 4'h0, 4'h0, 32'h0,
                      4'h2, 0, 8'h00, 8'h22, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 4'h0, 4'h2, 32'h5500,
                      4'h2, 1, 8'h55, 8'h22, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 4'h0, 4'h0, 32'h0,
                      4'h2, 0, 8'h00, 8'h22, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 4'h8, 4'h1, 32'hAA,
                      4'h2, 0, 8'h00, 8'h22, 0, 0));
    vecs.push_back(mk(1, 8'h21, 0, 4'h0, 4'h0, 32'h0,
                      4'h2, 0, 8'h00, 8'h22, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 4'h2, 4'h0, 32'h6600,
                      4'h0, 0, 8'h66, 8'h01, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 4'h0, 4'h0, 32'h0,
                      4'h0, 0, 8'h66, 8'h01, 0, 0));
    vecs.push_back(mk(1, 8'h00, 0, 4'h0, 4'h0, 32'h0,
                      4'h0, 0, 8'h66, 8'h01, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 4'h0, 4'h0, 32'h0,
                      4'h0, 0, 8'h66, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'h71, 0, 4'h0, 4'h0, 32'h0,
                      4'h4, 0, 8'h66, 8'h71, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 4'h0, 4'h4, 32'h550000,
                      4'h4, 1, 8'h55, 8'h71, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 4'h4, 4'h0, 32'h0,
                      4'h0, 0, 8'h00, 8'h01, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 4'h0, 4'h0, 32'h0,
                      4'h0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(1, 8'h99, 1, 4'h0, 4'h0, 32'h0,
                      4'h0, 0, 8'h00, 8'hEE, 1, 0));
    for (int i = 0; i < 9; i++)
      vecs.push_back(mk(0, 8'h00, 1, 4'h0, 4'h0, 32'h0,
                        4'h0, 0, 8'h00, 8'hEE, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 4'h0, 4'h0, 32'h0,
                      4'h0, 1, 8'h3F, 8'h01, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 4'h0, 4'h0, 32'h0,
                      4'h0, 0, 8'h3F, 8'h00, 0, 0));

    foreach (vecs[i]) apply(vecs[i], i);
    clear_in();

    // Asynchronous reset in the middle of a run.
    rx_ready = 1'b1;
    rx_data = 8'h22;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    chk("midrun act", 32'(act0), 32'h2);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("async act", 32'(act0), 32'h0);
    chk("async code", 32'(code0), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    do_reset();
    wd_run(1'b0, hi, tos);
    chk("wd active cycles", 32'(hi), 32'd100);
    chk("wd pulses", 32'(tos), 32'd1);
    do_reset();
    wd_run(1'b1, hi, tos);
    chk("wd done act cycles", 32'(hi), 32'd100);
    chk("wd done pulses", 32'(tos), 32'd0);

    clear_in();
    do_reset();
    rx_ready = 1'b1;
    rx_data = 8'h10;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    chk("dup10 act", 32'(act2), 32'h1);
    chk("dup10 code", 32'(code2), 32'h10);
    do_reset();
    rx_ready = 1'b1;
    rx_data = 8'h30;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    chk("dup30 act", 32'(act2), 32'h4);
    chk("dup30 code", 32'(code2), 32'h30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
